// File: rtl/fetch_pkg.sv
// Shared defaults and sizing helpers for the instruction fetch unit.
// Imported by the fetch queue and the fetch unit top.
package fetch_pkg;

  localparam int unsigned       FETCH_ADDR_W   = 32;
  localparam int unsigned       FETCH_DATA_W   = 32;
  localparam int unsigned       FETCH_DEPTH    = 4;
  localparam logic [31:0]       FETCH_RESET_PC = 32'h0000_0000;
  localparam int unsigned       FETCH_PC_INC   = 1;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; head is read straight from storage.
// Used both for the {pc, inst} queue and for the PC tags of outstanding reads.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_ADDR_W + FETCH_DATA_W,
  parameter int unsigned DEPTH = FETCH_DEPTH,
  localparam int unsigned CW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && valid && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues in-order reads under a credit limit,
// queues returned words with their PC, and drops responses orphaned by a redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       DATA_W   = FETCH_DATA_W,
  parameter int unsigned       DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int unsigned       PC_INC   = FETCH_PC_INC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int unsigned       CW      = cnt_w(DEPTH);
  localparam int unsigned       SW      = CW + 1;
  localparam int unsigned       QW      = ADDR_W + DATA_W;
  localparam logic [SW-1:0]     DEPTH_S = SW'(DEPTH);
  localparam logic [ADDR_W-1:0] INC     = ADDR_W'(PC_INC);
  localparam logic [CW-1:0]     ONE     = CW'(1);

  logic              req_q;
  logic              issue;
  logic              keep;
  logic              pop;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     inflight_nxt;
  logic [CW-1:0]     count_nxt;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     tag_count;
  logic [SW-1:0]     credit_nxt;
  logic [ADDR_W-1:0] tag_pc;
  logic              tag_valid;
  logic              tag_full;
  logic              q_full;
  logic [QW-1:0]     q_push_data;
  logic [QW-1:0]     q_head;

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc;
  assign issue     = req_q && imem_gnt;
  // A response is kept only when nothing is owed to a redirect and no redirect is landing now.
  assign keep      = imem_rvalid && (drop == '0) && !redirect_valid;
  assign pop       = inst_valid && inst_ready && !redirect_valid;

  assign q_push_data = {tag_pc, imem_rdata};
  assign inst_pc     = q_head[QW-1:DATA_W];
  assign inst_data   = q_head[DATA_W-1:0];

  always_comb begin
    inflight_nxt = inflight;
    if (issue)       inflight_nxt = inflight_nxt + ONE;
    if (imem_rvalid) inflight_nxt = inflight_nxt - ONE;

    count_nxt = q_count;
    if (redirect_valid) begin
      count_nxt = '0;
    end else begin
      if (keep) count_nxt = count_nxt + ONE;
      if (pop)  count_nxt = count_nxt - ONE;
    end

    credit_nxt = SW'(count_nxt) + SW'(inflight_nxt);
  end

  // The request is registered from next-state counts, so req never sees a combinational input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      req_q    <= 1'b0;
    end else begin
      req_q    <= (credit_nxt < DEPTH_S);
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        drop     <= inflight_nxt;
      end else begin
        if (issue) fetch_pc <= fetch_pc + INC;
        if (imem_rvalid && (drop != '0)) drop <= drop - ONE;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (issue && !redirect_valid),
    .push_data (fetch_pc),
    .pop       (keep),
    .head      (tag_pc),
    .valid     (tag_valid),
    .full      (tag_full),
    .count     (tag_count)
  );

  fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (keep),
    .push_data (q_push_data),
    .pop       (pop),
    .head      (q_head),
    .valid     (inst_valid),
    .full      (q_full),
    .count     (q_count)
  );

  a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
    drop <= inflight);
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (SW'(q_count) + SW'(inflight)) <= DEPTH_S);
  a_rvalid_owed: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (inflight != '0));
  a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
    keep |-> tag_valid);
  a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
    (issue && !redirect_valid) |-> !tag_full);
  a_tag_track: assert property (@(posedge clk) disable iff (!rst_n)
    (SW'(tag_count) + SW'(drop)) == SW'(inflight));
  a_queue_room: assert property (@(posedge clk) disable iff (!rst_n)
    keep |-> !q_full);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model plus a stream model
// that expects sequential PCs from the last redirect target.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_pc       (fetch_pc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  logic [31:0] popped[$];
  logic [31:0] exp_pc = '0;
  logic [31:0] req_pc = '0;
  int          n_issue = 0;
  int          n_pop = 0;
  int          valid_seen = 0;
  int          gnt_mode = 0;
  int          rv_mode = 0;
  int          rdy_mode = 0;
  bit          do_redir = 1'b0;
  logic [31:0] redir_target = '0;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
  } redir_vec_t;

  redir_vec_t vecs[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit pick(input int mode);
    if (mode == 2) return bit'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs away from the edge, update models.
  task automatic step();
    bit rv;
    bit issue;
    bit pop;
    rv = 1'b0;
    if (pend_addr.size() > 0 && pend_cyc[0] < cyc) begin
      if (rv_mode == 1) rv = 1'b1;
      else if (rv_mode == 2) rv = ($urandom_range(0, 2) != 0);
    end
    imem_gnt       = pick(gnt_mode);
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(pend_addr[0]) : $urandom;
    inst_ready     = pick(rdy_mode);
    redirect_valid = do_redir;
    redirect_pc    = redir_target;
    #1;
    issue = imem_req && imem_gnt;
    pop   = inst_valid && inst_ready && !redirect_valid;
    valid_seen += int'(inst_valid);
    if (issue) begin
      chk("issue_credit", 32'(pend_addr.size() < DEPTH), 32'd1);
      chk("issue_addr", imem_addr, req_pc);
      pend_addr.push_back(imem_addr);
      pend_cyc.push_back(cyc);
      n_issue++;
    end
    if (rv) begin
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
    end
    if (pop) begin
      chk("pop_pc", inst_pc, exp_pc);
      chk("pop_data", inst_data, mem_word(exp_pc));
      popped.push_back(inst_pc);
      exp_pc = exp_pc + 32'd1;
      n_pop++;
    end
    if (redirect_valid) begin
      exp_pc = redir_target;
      req_pc = redir_target;
    end else if (issue) begin
      req_pc = req_pc + 32'd1;
    end
    do_redir = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready = 1'b0;
    do_redir = 1'b0;
    pend_addr.delete();
    pend_cyc.delete();
    popped.delete();
    exp_pc = '0;
    req_pc = '0;
    n_issue = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int i;
    i = 0;
    while (popped.size() < n && i < budget) begin
      step();
      i++;
    end
    chk("pop_timeout", 32'(popped.size() >= n), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0041};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5679};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0001};

    // Reset state
    do_reset();
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);

    // Streaming at one instruction per cycle
    do_reset();
    gnt_mode = 1; rv_mode = 1; rdy_mode = 1;
    repeat (5) step();
    p0 = n_pop;
    repeat (10) step();
    chk("stream_rate", 32'(n_pop - p0), 32'd10);
    chk("stream_first_pc", popped[0], 32'd0);

    // Credit limit with decode stalled
    do_reset();
    gnt_mode = 1; rv_mode = 1; rdy_mode = 0;
    repeat (12) step();
    chk("stall_issues", 32'(n_issue), 32'd4);
    chk("stall_req", 32'(imem_req), 32'd0);
    rdy_mode = 1;
    step();
    chk("resume_pop_pc", popped[0], 32'd0);
    chk("resume_req", 32'(imem_req), 32'd1);

    // Redirect with three reads outstanding
    do_reset();
    gnt_mode = 1; rv_mode = 0; rdy_mode = 1;
    for (int i = 0; i < 20 && n_issue < 3; i++) step();
    chk("three_issued", 32'(n_issue), 32'd3);
    gnt_mode = 0;
    do_redir = 1'b1; redir_target = 32'h40;
    step();
    chk("redir3_fetch_pc", fetch_pc, 32'h40);
    rv_mode = 1; valid_seen = 0; popped.delete();
    repeat (5) step();
    chk("redir3_no_stale", 32'(valid_seen), 32'd0);
    gnt_mode = 1;
    wait_pops(1, 20);
    chk("redir3_first_pc", popped[0], 32'h40);

    // Redirect coinciding with issue and response
    do_reset();
    gnt_mode = 1; rv_mode = 0; rdy_mode = 1;
    for (int i = 0; i < 20 && n_issue < 2; i++) step();
    rv_mode = 1;
    do_redir = 1'b1; redir_target = 32'h80;
    p0 = n_issue;
    step();
    chk("redir4_issue_same_cycle", 32'(n_issue - p0), 32'd1);
    chk("redir4_fetch_pc", fetch_pc, 32'h80);
    gnt_mode = 0; valid_seen = 0; popped.delete();
    repeat (4) step();
    chk("redir4_no_stale", 32'(valid_seen), 32'd0);
    gnt_mode = 1;
    wait_pops(1, 20);
    chk("redir4_first_pc", popped[0], 32'h80);

    // Redirect targets from the table, including the address wrap
    do_reset();
    gnt_mode = 1; rv_mode = 1; rdy_mode = 1;
    repeat (4) step();
    for (int v = 0; v < 5; v++) begin
      do_redir = 1'b1; redir_target = vecs[v].target;
      step();
      chk("tbl_fetch_pc", fetch_pc, vecs[v].target);
      popped.delete();
      wait_pops(2, 30);
      chk("tbl_first_pc", popped[0], vecs[v].exp_first);
      chk("tbl_second_pc", popped[1], vecs[v].exp_second);
    end

    // Asynchronous reset with words queued and reads outstanding
    do_reset();
    gnt_mode = 1; rv_mode = 0; rdy_mode = 0;
    for (int i = 0; i < 20 && n_issue < 4; i++) step();
    gnt_mode = 0; rv_mode = 1;
    repeat (2) step();
    rv_mode = 0;
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'd0);
    chk("async_rst_valid", 32'(inst_valid), 32'd0);
    chk("async_rst_fetch_pc", fetch_pc, 32'd0);
    chk("async_rst_addr", imem_addr, 32'd0);
    chk("async_rst_inst_pc", inst_pc, 32'd0);
    chk("async_rst_inst_data", inst_data, 32'd0);
    do_reset();
    gnt_mode = 1; rv_mode = 1; rdy_mode = 1;
    wait_pops(1, 20);
    chk("restart_first_pc", popped[0], 32'd0);

    // Randomised traffic with occasional redirects
    do_reset();
    gnt_mode = 2; rv_mode = 2; rdy_mode = 2;
    n_pop = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_redir = 1'b1;
        if ($urandom_range(0, 3) == 0) redir_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else redir_target = $urandom;
      end
      step();
    end
    chk("random_progress", 32'(n_pop > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
